// File: rtl/square_move_scheduler.sv
// Turns one-cycle button pulses into queued move commands and applies at most
// one clamped move per video frame, aligned to the frame-start pulse.
module square_move_scheduler #(
  parameter int H_ACT  = 1920,
  parameter int V_ACT  = 1080,
  parameter int SIZE   = 64,
  parameter int STEP   = 16,
  parameter int DEPTH  = 4,
  parameter int X_INIT = 928,
  parameter int Y_INIT = 508
) (
  input  logic               clk_148Mhz,
  input  logic               reset,
  input  logic               buton_apasatL,
  input  logic               buton_apasatR,
  input  logic               buton_apasatU,
  input  logic               buton_apasatD,
  input  logic               frame_start,
  output logic signed [11:0] x_pos,
  output logic signed [11:0] y_pos,
  output logic [2:0]         fifo_count,
  output logic               drop,
  output logic               moving
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [12:0] X_MAX  = 13'(H_ACT - SIZE);
  localparam logic signed [12:0] Y_MAX  = 13'(V_ACT - SIZE);
  localparam logic signed [12:0] STEP_S = 13'(STEP);

  typedef enum logic {IDLE, APPLY} state_t;
  state_t state, state_nxt;

  logic [3:0]    press, pend, clr, lost;
  logic          full, push, pop;
  logic [1:0]    push_code, dir;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic signed [12:0] sx, sy, nx, ny;

  // bit index doubles as the command code: L=0, R=1, U=2, D=3
  assign press = {buton_apasatD, buton_apasatU, buton_apasatR, buton_apasatL};
  assign full  = (fifo_count == 3'(DEPTH));
  assign pop   = (state == IDLE) && frame_start && (fifo_count != 3'd0);

  always_comb begin
    push      = 1'b0;
    push_code = 2'd0;
    clr       = 4'b0000;
    if (!full) begin
      if (pend[0])      begin push = 1'b1; push_code = 2'd0; clr = 4'b0001; end
      else if (pend[1]) begin push = 1'b1; push_code = 2'd1; clr = 4'b0010; end
      else if (pend[2]) begin push = 1'b1; push_code = 2'd2; clr = 4'b0100; end
      else if (pend[3]) begin push = 1'b1; push_code = 2'd3; clr = 4'b1000; end
    end
  end

  // a press landing on a flag that is leaving this cycle simply re-arms it
  assign lost = press & pend & ~clr;

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      pend <= 4'b0000;
      drop <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | press;
      drop <= |lost;
    end
  end

  always_ff @(posedge clk_148Mhz) begin
    if (push) mem[wptr] <= push_code;
  end

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= 3'd0;
      dir        <= 2'd0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        dir  <= mem[rptr];
      end
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb moving = (state == APPLY);

  function automatic logic signed [12:0] clamp(input logic signed [12:0] v,
                                               input logic signed [12:0] hi);
    if (v < 13'sd0)   return 13'sd0;
    else if (v > hi)  return hi;
    else              return v;
  endfunction

  assign sx = {x_pos[11], x_pos};
  assign sy = {y_pos[11], y_pos};

  always_comb begin
    nx = sx;
    ny = sy;
    case (dir)
      2'd0: nx = clamp(sx - STEP_S, X_MAX);
      2'd1: nx = clamp(sx + STEP_S, X_MAX);
      2'd2: ny = clamp(sy - STEP_S, Y_MAX);
      2'd3: ny = clamp(sy + STEP_S, Y_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      x_pos <= 12'(X_INIT);
      y_pos <= 12'(Y_INIT);
    end else if (state == APPLY) begin
      x_pos <= nx[11:0];
      y_pos <= ny[11:0];
    end
  end
endmodule
